// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Single-port data memory for a processor with a secondary
//               loader write port. The memory self-clears on reset and
//               answers with 1-cycle, write-first registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] address,
    input  logic          WR,
    input  logic [DW-1:0] writeData,
    output logic [DW-1:0] readData,
    output logic          busy,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          err_wr_init
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic [AW-1:0] w_init_cnt_nxt;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] w_rdata_nxt;
    logic          r_err;
    logic          w_err_nxt;

    logic          w_proc_we;
    logic          w_ld_ready;
    logic          w_ld_fire;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;

    // Processor access always wins; the loader only gets idle READY cycles.
    always_comb begin
        w_proc_we  = (r_state == ST_READY) && WR;
        w_ld_ready = (r_state == ST_READY) && !WR;
        w_ld_fire  = ld_valid && w_ld_ready;
    end

    // Next-state logic; init_cnt freezes once READY so it cannot start a second pass.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_err_nxt      = r_err;
        case (r_state)
            ST_INIT: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (WR) begin
                    w_err_nxt = 1'b1;
                end
                if (r_init_cnt == c_last_addr) begin
                    w_state_nxt    = ST_READY;
                    w_init_cnt_nxt = r_init_cnt;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_init_cnt_nxt = '0;
            end
        endcase
    end

    // Single memory write port shared by init clearing, processor and loader.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (r_state == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_init_cnt;
        end else if (w_proc_we) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = address;
            w_mem_wdata = writeData;
        end else if (w_ld_fire) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = ld_addr;
            w_mem_wdata = ld_data;
        end
    end

    // Write-first read: a same-cycle write to the read address bypasses the array.
    always_comb begin
        w_rdata_nxt = '0;
        if (r_state == ST_READY) begin
            if (w_mem_we && (w_mem_waddr == address)) begin
                w_rdata_nxt = w_mem_wdata;
            end else begin
                w_rdata_nxt = r_mem[address];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign readData    = r_rdata;
    assign busy        = (r_state == ST_INIT);
    assign ld_ready    = w_ld_ready;
    assign err_wr_init = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] address;
    logic          WR;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;
    logic          busy;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          err_wr_init;

    int n_cmp;
    int n_err;

    data_mem_responder #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .WR          (WR),
        .writeData   (writeData),
        .readData    (readData),
        .busy        (busy),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .err_wr_init (err_wr_init)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the current point until busy drops; 256 expected.
    task automatic run_init(input string tag, input bit pulse_wr);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            WR        = pulse_wr && (cnt == 10);
            address   = 8'h05;
            writeData = 32'hBADBAD05;
            tick();
            cnt++;
            if (pulse_wr && cnt == 11) begin
                chk({tag, "_err_set"}, {31'd0, err_wr_init}, 32'd1);
                chk({tag, "_rd_init"}, readData, 32'd0);
            end
        end
        WR = 1'b0;
        chk({tag, "_init_len"}, cnt, 32'd256);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address = a;
        WR      = 1'b0;
        tick();
        chk(tag, readData, exp);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        address   = '0;
        WR        = 1'b0;
        writeData = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        #23;
        chk("rst_busy",   {31'd0, busy},        32'd1);
        chk("rst_rdata",  readData,             32'd0);
        chk("rst_ldrdy",  {31'd0, ld_ready},    32'd0);
        chk("rst_err",    {31'd0, err_wr_init}, 32'd0);

        // Release between edges, WR pulse on INIT cycle 10.
        @(posedge clk);
        #1 rst = 1'b1;
        run_init("init1", 1'b1);
        chk("ready_busy",  {31'd0, busy},     32'd0);
        chk("ready_ldrdy", {31'd0, ld_ready}, 32'd1);

        rd("rd_00", 8'h00, 32'd0);
        rd("rd_05_nowr", 8'h05, 32'd0);
        rd("rd_80", 8'h80, 32'd0);
        rd("rd_ff", 8'hFF, 32'd0);

        // Processor write then read back.
        address = 8'h04; WR = 1'b1; writeData = 32'h00000004;
        tick();
        rd("wr_rd_04", 8'h04, 32'h00000004);

        // Processor and loader collide: processor wins, loader held.
        address = 8'h10; WR = 1'b1; writeData = 32'hAAAA0010;
        ld_valid = 1'b1; ld_addr = 8'h11; ld_data = 32'h55550011;
        #1;
        chk("coll_ldrdy0", {31'd0, ld_ready}, 32'd0);
        tick();
        WR = 1'b0; address = 8'h11;
        #1;
        chk("coll_ldrdy1", {31'd0, ld_ready}, 32'd1);
        tick();
        chk("ld_wrfirst_11", readData, 32'h55550011);
        ld_valid = 1'b0;
        rd("coll_rd_10", 8'h10, 32'hAAAA0010);
        rd("coll_rd_11", 8'h11, 32'h55550011);

        // Loader request blocked by WR must not write.
        address = 8'h20; WR = 1'b1; writeData = 32'h20202020;
        ld_valid = 1'b1; ld_addr = 8'h21; ld_data = 32'h21212121;
        tick();
        ld_valid = 1'b0;
        rd("blk_rd_21", 8'h21, 32'd0);
        rd("blk_rd_20", 8'h20, 32'h20202020);

        // Write-first on processor write to the read address.
        address = 8'h2C; WR = 1'b1; writeData = 32'hDEADBEEF;
        tick();
        chk("wrfirst_2c", readData, 32'hDEADBEEF);
        rd("hold_2c", 8'h2C, 32'hDEADBEEF);

        // Loader write-first on the read address.
        address = 8'h40; ld_valid = 1'b1; ld_addr = 8'h40; ld_data = 32'h12345678;
        tick();
        ld_valid = 1'b0;
        chk("ld_wrfirst_40", readData, 32'h12345678);
        chk("err_sticky", {31'd0, err_wr_init}, 32'd1);

        // Async reset from READY with non-zero read data.
        rd("pre_rst_2c", 8'h2C, 32'hDEADBEEF);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdata", readData,             32'd0);
        chk("arst_busy",  {31'd0, busy},        32'd1);
        chk("arst_err",   {31'd0, err_wr_init}, 32'd0);
        #10 rst = 1'b1;

        // Async reset again at INIT cycle 100.
        for (int i = 0; i < 100; i++) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_arst_busy",  {31'd0, busy},     32'd1);
        chk("mid_arst_ldrdy", {31'd0, ld_ready}, 32'd0);
        #3 rst = 1'b1;
        run_init("init2", 1'b0);
        chk("init2_err", {31'd0, err_wr_init}, 32'd0);
        rd("post_rd_2c", 8'h2C, 32'd0);
        rd("post_rd_40", 8'h40, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter AW, default 8, address width in bits.
REQ-002 SHALL have parameter DW, default 32, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of words (2**AW).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  AW  processor data address.
REQ-007 SHALL have port WR  input  1  processor write strobe, sampled on rising clk.
REQ-008 SHALL have port writeData  input  DW  processor write data.
REQ-009 SHALL have port readData  output  DW  registered read data to processor.
REQ-010 SHALL have port busy  output  1  high while memory initialisation runs.
REQ-011 SHALL have port ld_valid  input  1  loader request valid.
REQ-012 SHALL have port ld_addr  input  AW  loader write address.
REQ-013 SHALL have port ld_data  input  DW  loader write data.
REQ-014 SHALL have port ld_ready  output  1  loader request accepted this cycle.
REQ-015 SHALL have port err_wr_init  output  1  sticky: processor WR seen during INIT.

Function
REQ-016 SHALL implement a DEPTH x DW word array and a two-state FSM: INIT, READY.
REQ-017 INIT SHALL write 0 to mem[init_cnt] each cycle, init_cnt counting 0..DEPTH-1 (AW bits).
REQ-018 After the cycle clearing address DEPTH-1, state SHALL become READY; INIT lasts exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in INIT and 0 in READY; READY SHALL be held until reset.
REQ-020 In INIT: WR ignored (no write), ld_ready=0, readData held at 0.
REQ-021 In INIT, WR=1 on a rising edge SHALL set err_wr_init=1; it stays 1 until reset.
REQ-022 In READY, WR=1 on a rising edge SHALL write writeData to mem[address].
REQ-023 In READY, readData SHALL update every rising edge to mem[address]; latency exactly 1 cycle.
REQ-024 Read and write to the same address in the same cycle SHALL return the new writeData (write-first).
REQ-025 ld_ready SHALL be combinational: 1 iff state=READY and WR=0; processor has priority over loader.
REQ-026 A loader transfer SHALL occur on a rising edge when ld_valid=1 and ld_ready=1: mem[ld_addr]=ld_data.
REQ-027 If ld_valid=1 while ld_ready=0, the loader SHALL hold ld_addr/ld_data until accepted; no write occurs.
REQ-028 A loader write to the address being read SHALL make readData show ld_data the next cycle (write-first).
REQ-029 Address wrap: addresses are AW-bit; no out-of-range case exists; init_cnt SHALL not wrap past DEPTH-1 into a second pass.

Reset
REQ-030 rst=0 SHALL asynchronously force: state=INIT, init_cnt=0, readData=0, busy=1, err_wr_init=0, ld_ready=0.
REQ-031 Reset asserted mid-INIT or in READY SHALL restart INIT from address 0 on release; memory contents are undefined until INIT completes.
REQ-032 First INIT clear SHALL occur on the first rising edge with rst=1.

Verification
REQ-033 Reset release, count edges -> busy=1 for exactly 256 edges, then busy=0; readData=0 for all addresses read afterward.
REQ-034 READY: WR=1, address=8'h04, writeData=32'h00000004; next cycle WR=0, address=8'h04 -> readData=32'h00000004 one edge later.
REQ-035 READY: WR=1 and ld_valid=1 same cycle (addr 8'h10/8'h11) -> ld_ready=0, only mem[8'h10] written; loader accepted next cycle when WR=0, mem[8'h11]=ld_data.
REQ-036 READY: write 32'hDEADBEEF to 8'h2C while address=8'h2C -> readData=32'hDEADBEEF after that edge (write-first).
REQ-037 During INIT pulse WR=1 at cycle 10 -> no memory change, err_wr_init=1 and stays 1 through READY until rst=0.
REQ-038 Assert rst=0 at INIT cycle 100 (async, between edges) -> outputs reset immediately; after release busy lasts 256 more cycles.
